// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the divider datapath.
// FSM encoding, default widths and the divide-by-zero quotient.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N = 8;

  // Wide all-ones pattern, truncated to the quotient width at use
  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Shifts in the next dividend bit and subtracts the divisor if it fits.
module div_step import arith_pkg::*; #(
  parameter int N = DEF_N
) (
  input  logic [N:0]   rem_in,
  input  logic         q_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   rem_out,
  output logic         q_bit
);

  logic [N+1:0] sh;
  logic [N+1:0] trial;

  // One spare top bit makes the borrow an explicit sign
  assign sh      = {rem_in, q_msb};
  assign trial   = sh - {2'b00, divisor};
  assign q_bit   = ~trial[N+1];
  assign rem_out = q_bit ? trial[N:0] : sh[N:0];

endmodule

// File: rtl/seq_divider_16by8.sv
// Unsigned sequential restoring divider, 2N-bit by N-bit.
// One quotient bit per cycle with valid/ready on input and output.
module seq_divider_16by8 import arith_pkg::*; #(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int CNT_W = $clog2(2*N) + 1;

  state_t           state;
  logic [N:0]       rem;
  logic [2*N-1:0]   q;
  logic [N-1:0]     dvs;
  logic [CNT_W-1:0] cnt;
  logic [N:0]       rem_nx;
  logic             q_bit;

  div_step #(.N(N)) u_step (
    .rem_in  (rem),
    .q_msb   (q[2*N-1]),
    .divisor (dvs),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dvs         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            q        <= dividend;
            dvs      <= divisor;
            rem      <= '0;
            cnt      <= CNT_W'(2*N);
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= (2*N)'(DBZ_QUOTIENT);
              remainder   <= dividend[N-1:0];
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          q   <= {q[2*N-2:0], q_bit};
          cnt <= cnt - CNT_W'(1);
          // Last step publishes straight into the output registers
          if (cnt == CNT_W'(1)) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= {q[2*N-2:0], q_bit};
            remainder   <= rem_nx[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8.
// Results are compared against plain integer division.
module tb_seq_divider_16by8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  seq_divider_16by8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {div_by_zero, quotient, remainder}
  function automatic logic [24:0] model(input logic [15:0] a,
                                        input logic [7:0] b);
    if (b == 8'd0) return {1'b1, 16'hFFFF, a[7:0]};
    return {1'b0, a / {8'd0, b}, 8'(a % {8'd0, b})};
  endfunction

  function automatic int exp_lat(input logic [7:0] b);
    return (b == 8'd0) ? 1 : 17;
  endfunction

  task automatic start_div(input logic [15:0] a, input logic [7:0] b);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Latency counted in cycles: accept cycle T, result visible in cycle T+lat
  task automatic wait_result(output int lat);
    while (!out_valid && (cyc - acc_cyc) < 100) @(negedge clk);
    lat = cyc - acc_cyc + 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if ({div_by_zero, quotient, remainder} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {div_by_zero, quotient, remainder});
    end
  endtask

  task automatic test_directed;
    logic [15:0] a_t[8] = '{16'd65025, 16'd1000, 16'd65535, 16'd5,
                            16'd0, 16'd300, 16'd1234, 16'hABCD};
    logic [7:0]  b_t[8] = '{8'd255, 8'd7, 8'd1, 8'd9,
                            8'd37, 8'd12, 8'd0, 8'd0};
    int lat;
    for (int i = 0; i < 8; i++) begin
      start_div(a_t[i], b_t[i]);
      wait_result(lat);
      checks++;
      if ({div_by_zero, quotient, remainder} !== model(a_t[i], b_t[i])) begin
        errors++;
        $display("FAIL directed_%0d %0d/%0d got=%h exp=%h", i, a_t[i],
                 b_t[i], {div_by_zero, quotient, remainder},
                 model(a_t[i], b_t[i]));
      end
      checks++;
      if (lat !== exp_lat(b_t[i])) begin
        errors++;
        $display("FAIL latency_%0d got=%0d exp=%0d", i, lat,
                 exp_lat(b_t[i]));
      end
    end
    // Fixed spot values, independent of the model
    start_div(16'd1234, 8'd0);
    wait_result(lat);
    checks++;
    if ({div_by_zero, quotient, remainder} !== {1'b1, 16'hFFFF, 8'hD2}) begin
      errors++;
      $display("FAIL dbz_1234 got=%h exp=%h",
               {div_by_zero, quotient, remainder}, {1'b1, 16'hFFFF, 8'hD2});
    end
    start_div(16'd1000, 8'd7);
    wait_result(lat);
    checks++;
    if ({div_by_zero, quotient, remainder} !== {1'b0, 16'd142, 8'd6}) begin
      errors++;
      $display("FAIL div_1000_7 got=%h exp=%h",
               {div_by_zero, quotient, remainder}, {1'b0, 16'd142, 8'd6});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int lat;
    logic [24:0] exp = model(16'd50000, 8'd123);
    out_ready = 1'b0;
    start_div(16'd50000, 8'd123);
    wait_result(lat);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({out_valid, in_ready, div_by_zero, quotient, remainder} !==
          {2'b10, exp}) begin
        errors++;
        $display("FAIL hold_%0d got=%h exp=%h", i,
                 {out_valid, in_ready, div_by_zero, quotient, remainder},
                 {2'b10, exp});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, div_by_zero, quotient, remainder} !==
        {2'b01, exp}) begin
      errors++;
      $display("FAIL release got=%h exp=%h",
               {out_valid, in_ready, div_by_zero, quotient, remainder},
               {2'b01, exp});
    end
  endtask

  task automatic test_ignored_inputs;
    int lat;
    start_div(16'd40000, 8'd201);
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL calc_in_ready got=%b exp=0", in_ready);
    end
    in_valid = 1'b1;
    dividend = 16'd7;
    divisor  = 8'd3;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    checks++;
    if ({div_by_zero, quotient, remainder} !== model(16'd40000, 8'd201) ||
        lat != 17) begin
      errors++;
      $display("FAIL ignored got=%h lat=%0d exp=%h lat=17",
               {div_by_zero, quotient, remainder}, lat,
               model(16'd40000, 8'd201));
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ignored_idle got=%b exp=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_mid_reset;
    int lat;
    start_div(16'd60000, 8'd250);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quotient, remainder} !== {2'b10, 24'd0}) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=%h",
               {in_ready, out_valid, quotient, remainder}, {2'b10, 24'd0});
    end
    start_div(16'd300, 8'd12);
    wait_result(lat);
    checks++;
    if ({div_by_zero, quotient, remainder} !== {1'b0, 16'd25, 8'd0}) begin
      errors++;
      $display("FAIL after_reset got=%h exp=%h",
               {div_by_zero, quotient, remainder}, {1'b0, 16'd25, 8'd0});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int prev;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    for (int i = 0; i < 1500; i++) begin
      a = (i == 0) ? 8'd255 : (i == 1) ? 8'd1 : 8'($urandom_range(1, 255));
      b = (i == 0) ? 8'd255 : (i == 1) ? 8'd255 : 8'($urandom_range(1, 255));
      p = a * b;
      start_div(p, a);
      if (i > 0) begin
        checks++;
        if (acc_cyc - prev != 18) begin
          errors++;
          $display("FAIL throughput_%0d got=%0d exp=18", i, acc_cyc - prev);
        end
      end
      prev = acc_cyc;
      wait_result(lat);
      checks++;
      if ({div_by_zero, quotient, remainder} !== {1'b0, 8'd0, b, 8'd0} ||
          lat != 17) begin
        errors++;
        $display("FAIL roundtrip %0d/%0d got=%h lat=%0d exp=%h", p, a,
                 {div_by_zero, quotient, remainder}, lat,
                 {1'b0, 8'd0, b, 8'd0});
      end
    end
  endtask

  task automatic test_random;
    int lat;
    logic [15:0] a;
    logic [7:0]  b;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      start_div(a, b);
      wait_result(lat);
      checks++;
      if ({div_by_zero, quotient, remainder} !== model(a, b) ||
          lat != exp_lat(b)) begin
        errors++;
        $display("FAIL random %0d/%0d got=%h lat=%0d exp=%h lat=%0d", a, b,
                 {div_by_zero, quotient, remainder}, lat, model(a, b),
                 exp_lat(b));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure();
    test_ignored_inputs();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
